// File: rtl/r4w_spi_pkg.sv
// Shared state encoding, command-byte layout and register map for the R4W SPI register-bus slave.
package r4w_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4
  } state_t;

  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_BURST_BIT = 6;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_SF        = 8'h04;
  localparam logic [7:0] REG_STATUS    = 8'h08;
  localparam logic [7:0] REG_SYMBOL    = 8'h0C;
  localparam logic [7:0] REG_NCO_FREQ  = 8'h10;
  localparam logic [7:0] REG_NCO_PHASE = 8'h14;
  localparam logic [7:0] REG_DATA_I    = 8'h18;
  localparam logic [7:0] REG_DATA_Q    = 8'h1C;
  localparam logic [7:0] REG_ID        = 8'h20;
  localparam logic [7:0] REG_VERSION   = 8'h24;

endpackage

// File: rtl/r4w_spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous SPI pin with one-cycle rise/fall strobes.
module r4w_spi_sync_edge
  import r4w_spi_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_r;
  logic              prev_r;
  logic              sync_s;

  // Resynchronise the pin and remember the previous synchronised level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {STAGES{RESET_VAL}};
      prev_r  <= RESET_VAL;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], din};
      prev_r  <= chain_r[STAGES-1];
    end
  end

  assign sync_s = chain_r[STAGES-1];
  assign rise   = sync_s & ~prev_r;
  assign fall   = ~sync_s & prev_r;

endmodule

// File: rtl/r4w_spi_burst_slave.sv
// SPI mode-0 register-bus slave with parametrised address/data widths, burst auto-increment,
// a one-word read prefetch buffer and sticky underrun / partial-frame error flags.
module r4w_spi_burst_slave
  import r4w_spi_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int ADDR_STRIDE = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              xfer_active,
  output logic              err_underrun,
  output logic              err_partial,
  input  logic              err_clr
);

  localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ADDR_STRIDE);

  state_t             state_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [SH_W-1:0]    shift_r;
  logic [SH_W-1:0]    shift_next_s;
  logic [ADDR_W-1:0]  addr_r;
  logic [ADDR_W-1:0]  next_rd_addr_s;
  logic               write_r;
  logic               burst_r;
  logic [DATA_W-1:0]  rd_shift_r;
  logic [DATA_W-1:0]  buf_r;
  logic               buf_valid_r;
  logic               rd_pending_r;
  logic [DATA_W-1:0]  load_word_s;
  logic               underrun_s;
  logic               ack_rd_s;
  logic               partial_evt_s;
  logic               underrun_evt_s;
  logic [SYNC_STAGES-1:0] mosi_chain_r;
  logic               mosi_sync_s;
  logic               sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
  logic               miso_r, miso_oe_r, bus_req_r, bus_we_r, xfer_active_r;
  logic [ADDR_W-1:0]  bus_addr_r;
  logic [DATA_W-1:0]  bus_wdata_r;
  logic               err_underrun_r, err_partial_r;

  r4w_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(spi_sclk), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  // cs_n resets to "asserted" so a reset in mid-frame cannot fake a falling edge afterwards.
  r4w_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(spi_cs_n), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  // MOSI is only resynchronised; the sclk strobes qualify it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_chain_r <= {SYNC_STAGES{1'b0}};
    end else begin
      mosi_chain_r <= {mosi_chain_r[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign mosi_sync_s    = mosi_chain_r[SYNC_STAGES-1];
  assign shift_next_s   = {shift_r[SH_W-2:0], mosi_sync_s};
  assign ack_rd_s       = bus_ack & rd_pending_r;
  assign next_rd_addr_s = burst_r ? (addr_r + STRIDE) : addr_r;

  // Word presented at a read-word boundary: prefetched, arriving this cycle, or zeros.
  always_comb begin
    load_word_s = {DATA_W{1'b0}};
    underrun_s  = 1'b0;
    if (buf_valid_r) begin
      load_word_s = buf_r;
    end else if (ack_rd_s) begin
      load_word_s = bus_rdata;
    end else begin
      underrun_s = 1'b1;
    end
  end

  assign partial_evt_s  = cs_rise_s && (state_r == ST_ADDR || state_r == ST_WDATA)
                          && (bit_cnt_r != {CNT_W{1'b0}});
  assign underrun_evt_s = !cs_rise_s && (state_r == ST_RDATA) && sclk_fall_s
                          && (bit_cnt_r == {CNT_W{1'b0}}) && underrun_s;

  // Frame sequencer: command, address, write data or read data, with bus strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= {CNT_W{1'b0}};
      shift_r       <= {SH_W{1'b0}};
      addr_r        <= {ADDR_W{1'b0}};
      write_r       <= 1'b0;
      burst_r       <= 1'b0;
      rd_shift_r    <= {DATA_W{1'b0}};
      buf_r         <= {DATA_W{1'b0}};
      buf_valid_r   <= 1'b0;
      rd_pending_r  <= 1'b0;
      miso_r        <= 1'b0;
      miso_oe_r     <= 1'b0;
      bus_req_r     <= 1'b0;
      bus_we_r      <= 1'b0;
      bus_addr_r    <= {ADDR_W{1'b0}};
      bus_wdata_r   <= {DATA_W{1'b0}};
      xfer_active_r <= 1'b0;
    end else begin
      bus_req_r <= 1'b0;
      if (ack_rd_s && state_r == ST_RDATA) begin
        buf_r        <= bus_rdata;
        buf_valid_r  <= 1'b1;
        rd_pending_r <= 1'b0;
      end
      if (cs_rise_s) begin
        state_r       <= ST_IDLE;
        xfer_active_r <= 1'b0;
        miso_r        <= 1'b0;
        miso_oe_r     <= 1'b0;
        rd_pending_r  <= 1'b0;
        buf_valid_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (cs_fall_s) begin
              state_r       <= ST_CMD;
              bit_cnt_r     <= {CNT_W{1'b0}};
              xfer_active_r <= 1'b1;
            end
          end
          ST_CMD: begin
            if (sclk_rise_s) begin
              shift_r <= shift_next_s;
              if (bit_cnt_r == CNT_W'(7)) begin
                write_r   <= shift_next_s[CMD_WRITE_BIT];
                burst_r   <= shift_next_s[CMD_BURST_BIT];
                bit_cnt_r <= {CNT_W{1'b0}};
                state_r   <= ST_ADDR;
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise_s) begin
              shift_r <= shift_next_s;
              if (bit_cnt_r == CNT_W'(ADDR_W - 1)) begin
                addr_r    <= shift_next_s[ADDR_W-1:0];
                bit_cnt_r <= {CNT_W{1'b0}};
                if (write_r) begin
                  state_r <= ST_WDATA;
                end else begin
                  state_r      <= ST_RDATA;
                  miso_oe_r    <= 1'b1;
                  bus_req_r    <= 1'b1;
                  bus_we_r     <= 1'b0;
                  bus_addr_r   <= shift_next_s[ADDR_W-1:0];
                  rd_pending_r <= 1'b1;
                  buf_valid_r  <= 1'b0;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end
            end
          end
          ST_WDATA: begin
            if (sclk_rise_s) begin
              shift_r <= shift_next_s;
              if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                bus_req_r   <= 1'b1;
                bus_we_r    <= 1'b1;
                bus_addr_r  <= addr_r;
                bus_wdata_r <= shift_next_s[DATA_W-1:0];
                bit_cnt_r   <= {CNT_W{1'b0}};
                if (burst_r) begin
                  addr_r <= addr_r + STRIDE;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end
            end
          end
          ST_RDATA: begin
            if (sclk_fall_s) begin
              if (bit_cnt_r == {CNT_W{1'b0}}) begin
                miso_r     <= load_word_s[DATA_W-1];
                rd_shift_r <= {load_word_s[DATA_W-2:0], 1'b0};
                bit_cnt_r  <= CNT_W'(1);
                // On underrun the outstanding read is still in flight, so nothing new is issued.
                if (!underrun_s) begin
                  buf_valid_r  <= 1'b0;
                  bus_req_r    <= 1'b1;
                  bus_we_r     <= 1'b0;
                  bus_addr_r   <= next_rd_addr_s;
                  addr_r       <= next_rd_addr_s;
                  rd_pending_r <= 1'b1;
                end
              end else begin
                miso_r     <= rd_shift_r[DATA_W-1];
                rd_shift_r <= {rd_shift_r[DATA_W-2:0], 1'b0};
                if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                  bit_cnt_r <= {CNT_W{1'b0}};
                end else begin
                  bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                end
              end
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  // Sticky errors; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underrun_r <= 1'b0;
      err_partial_r  <= 1'b0;
    end else begin
      if (underrun_evt_s) begin
        err_underrun_r <= 1'b1;
      end else if (err_clr) begin
        err_underrun_r <= 1'b0;
      end
      if (partial_evt_s) begin
        err_partial_r <= 1'b1;
      end else if (err_clr) begin
        err_partial_r <= 1'b0;
      end
    end
  end

  assign spi_miso     = miso_r;
  assign spi_miso_oe  = miso_oe_r;
  assign bus_req      = bus_req_r;
  assign bus_we       = bus_we_r;
  assign bus_addr     = bus_addr_r;
  assign bus_wdata    = bus_wdata_r;
  assign xfer_active  = xfer_active_r;
  assign err_underrun = err_underrun_r;
  assign err_partial  = err_partial_r;

endmodule

// File: tb/tb_r4w_spi_burst_slave.sv
// Directed, table-driven bench for r4w_spi_burst_slave with a latency-configurable bus model.
module tb_r4w_spi_burst_slave;
  import r4w_spi_pkg::*;

  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, bus_req, bus_we, xfer_active, err_underrun, err_partial;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        err_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  int          ack_lat = 2;
  int          rd_mode = 0;
  int          ack_cnt = 0;
  logic [15:0] ack_addr = 16'h0;
  logic        req_we_q[$];
  logic [15:0] req_addr_q[$];
  logic [31:0] req_wdata_q[$];

  always #5 clk = ~clk;

  r4w_spi_burst_slave dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .xfer_active(xfer_active), .err_underrun(err_underrun), .err_partial(err_partial),
    .err_clr(err_clr)
  );

  // Register-file model: logs every request and acks the latest one after ack_lat cycles.
  initial begin
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          bus_ack   = 1'b1;
          bus_rdata = (rd_mode == 0) ? 32'h52344C49 : (32'(ack_addr) << 1);
        end
      end
      if (bus_req === 1'b1) begin
        req_we_q.push_back(bus_we);
        req_addr_q.push_back(bus_addr);
        req_wdata_q.push_back(bus_wdata);
        ack_cnt  = ack_lat;
        ack_addr = bus_addr;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    req_we_q.delete();
    req_addr_q.delete();
    req_wdata_q.delete();
  endtask

  task automatic frame_begin();
    spi_cs_n = 1'b0;
    #(2 * HALF);
  endtask

  // The frame ends with cs_n rising while sclk is still high, so no trailing read load occurs.
  task automatic frame_end();
    spi_cs_n = 1'b1;
    #(HALF);
    spi_sclk = 1'b0;
    #(4 * HALF);
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n, output logic [31:0] got,
                            output logic oe_all);
    got    = 32'h0;
    oe_all = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      spi_sclk = 1'b0;
      spi_mosi = v[i];
      #(HALF);
      spi_sclk = 1'b1;
      got    = {got[30:0], spi_miso};
      oe_all = oe_all & spi_miso_oe;
      #(HALF);
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr, input int nw,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                           output logic [31:0] q0, output logic [31:0] q1, output logic [31:0] q2,
                           output logic oe_data);
    logic [31:0] w, q;
    logic        oe;
    q0 = 32'h0; q1 = 32'h0; q2 = 32'h0;
    oe_data = 1'b1;
    frame_begin();
    shift_bits(32'(cmd), 8, q, oe);
    shift_bits(32'(addr), 16, q, oe);
    for (int i = 0; i < nw; i++) begin
      w = (i == 0) ? d0 : ((i == 1) ? d1 : d2);
      shift_bits(w, 32, q, oe);
      oe_data = oe_data & oe;
      if (i == 0) q0 = q;
      else if (i == 1) q1 = q;
      else q2 = q;
    end
    frame_end();
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    int          nw;
    logic [31:0] d [3];
    logic [15:0] ea [3];
  } wvec_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    int          nw;
    int          mode;
    int          lat;
    logic [31:0] eq [3];
    int          nreq;
    logic [15:0] ea [4];
    logic        eu;
  } rvec_t;

  wvec_t wv [4];
  rvec_t rv [3];

  initial begin
    logic [31:0] q0, q1, q2, q;
    logic        oe;

    wv[0] = '{cmd: 8'h80, addr: 16'h0004, nw: 1, d: '{32'h00000008, 32'h0, 32'h0},
              ea: '{16'h0004, 16'h0, 16'h0}};
    wv[1] = '{cmd: 8'hC0, addr: 16'h0010, nw: 3, d: '{32'h00010000, 32'h00000011, 32'h00000022},
              ea: '{16'h0010, 16'h0014, 16'h0018}};
    wv[2] = '{cmd: 8'hC0, addr: 16'hFFFC, nw: 2, d: '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0},
              ea: '{16'hFFFC, 16'h0000, 16'h0}};
    wv[3] = '{cmd: 8'h80, addr: 16'h0024, nw: 2, d: '{32'hCAFEF00D, 32'h0BADBEEF, 32'h0},
              ea: '{16'h0024, 16'h0024, 16'h0}};

    rv[0] = '{cmd: 8'h00, addr: 16'(REG_ID), nw: 1, mode: 0, lat: 2,
              eq: '{32'h52344C49, 32'h0, 32'h0}, nreq: 2,
              ea: '{16'h0020, 16'h0020, 16'h0, 16'h0}, eu: 1'b0};
    rv[1] = '{cmd: 8'h40, addr: 16'h0018, nw: 3, mode: 1, lat: 2,
              eq: '{32'h00000030, 32'h00000038, 32'h00000040}, nreq: 4,
              ea: '{16'h0018, 16'h001C, 16'h0020, 16'h0024}, eu: 1'b0};
    rv[2] = '{cmd: 8'h00, addr: 16'h0008, nw: 1, mode: 1, lat: 40,
              eq: '{32'h00000000, 32'h0, 32'h0}, nreq: 1,
              ea: '{16'h0008, 16'h0, 16'h0, 16'h0}, eu: 1'b1};

    // Reset state
    #33;
    check("rst_miso", 32'(spi_miso), 32'h0);
    check("rst_oe", 32'(spi_miso_oe), 32'h0);
    check("rst_req", 32'(bus_req), 32'h0);
    check("rst_addr", 32'(bus_addr), 32'h0);
    check("rst_active", 32'(xfer_active), 32'h0);
    rst_n = 1'b1;
    #100;

    // Write vectors
    for (int r = 0; r < 4; r++) begin
      clear_log();
      ack_lat = 2;
      run_frame(wv[r].cmd, wv[r].addr, wv[r].nw, wv[r].d[0], wv[r].d[1], wv[r].d[2],
                q0, q1, q2, oe);
      check($sformatf("w%0d_nreq", r), 32'(req_addr_q.size()), 32'(wv[r].nw));
      for (int j = 0; j < wv[r].nw; j++) begin
        if (j < req_addr_q.size()) begin
          check($sformatf("w%0d_we%0d", r, j), 32'(req_we_q[j]), 32'h1);
          check($sformatf("w%0d_addr%0d", r, j), 32'(req_addr_q[j]), 32'(wv[r].ea[j]));
          check($sformatf("w%0d_data%0d", r, j), req_wdata_q[j], wv[r].d[j]);
        end
      end
      check($sformatf("w%0d_partial", r), 32'(err_partial), 32'h0);
    end

    // Read vectors (last one uses a slow bus and must underrun)
    for (int r = 0; r < 3; r++) begin
      clear_log();
      ack_lat = rv[r].lat;
      rd_mode = rv[r].mode;
      run_frame(rv[r].cmd, rv[r].addr, rv[r].nw, 32'h0, 32'h0, 32'h0, q0, q1, q2, oe);
      check($sformatf("r%0d_word0", r), q0, rv[r].eq[0]);
      if (rv[r].nw > 1) check($sformatf("r%0d_word1", r), q1, rv[r].eq[1]);
      if (rv[r].nw > 2) check($sformatf("r%0d_word2", r), q2, rv[r].eq[2]);
      check($sformatf("r%0d_oe", r), 32'(oe), 32'h1);
      check($sformatf("r%0d_underrun", r), 32'(err_underrun), 32'(rv[r].eu));
      check($sformatf("r%0d_nreq", r), 32'(req_addr_q.size()), 32'(rv[r].nreq));
      for (int j = 0; j < rv[r].nreq; j++) begin
        if (j < req_addr_q.size()) begin
          check($sformatf("r%0d_we%0d", r, j), 32'(req_we_q[j]), 32'h0);
          check($sformatf("r%0d_addr%0d", r, j), 32'(req_addr_q[j]), 32'(rv[r].ea[j]));
        end
      end
      check($sformatf("r%0d_oe_after", r), 32'(spi_miso_oe), 32'h0);
    end

    // err_clr releases the sticky underrun flag
    err_clr = 1'b1;
    #10;
    err_clr = 1'b0;
    #10;
    check("underrun_cleared", 32'(err_underrun), 32'h0);
    ack_lat = 2;

    // Abort after 12 bits of a write data word
    clear_log();
    frame_begin();
    shift_bits(32'h80, 8, q, oe);
    shift_bits(32'h0008, 16, q, oe);
    shift_bits(32'h00000ABC, 12, q, oe);
    frame_end();
    check("abort_nreq", 32'(req_addr_q.size()), 32'h0);
    check("abort_partial", 32'(err_partial), 32'h1);
    err_clr = 1'b1;
    #10;
    err_clr = 1'b0;
    #10;
    check("partial_cleared", 32'(err_partial), 32'h0);

    // Reset in the middle of the address phase
    clear_log();
    frame_begin();
    check("mid_active", 32'(xfer_active), 32'h1);
    shift_bits(32'h80, 8, q, oe);
    shift_bits(32'h00, 8, q, oe);
    rst_n = 1'b0;
    #20;
    check("mid_rst_active", 32'(xfer_active), 32'h0);
    check("mid_rst_addr", 32'(bus_addr), 32'h0);
    check("mid_rst_wdata", bus_wdata, 32'h0);
    check("mid_rst_we", 32'(bus_we), 32'h0);
    check("mid_rst_errs", {30'h0, err_underrun, err_partial}, 32'h0);
    rst_n = 1'b1;
    #20;
    shift_bits(32'h10, 8, q, oe);
    shift_bits(32'h11111111, 32, q, oe);
    check("mid_idle_active", 32'(xfer_active), 32'h0);
    frame_end();
    check("mid_nreq", 32'(req_addr_q.size()), 32'h0);
    check("mid_partial", 32'(err_partial), 32'h0);

    // A full transaction works after the mid-frame reset
    clear_log();
    run_frame(8'h80, 16'(REG_NCO_FREQ), 1, 32'h12345678, 32'h0, 32'h0, q0, q1, q2, oe);
    check("post_nreq", 32'(req_addr_q.size()), 32'h1);
    if (req_addr_q.size() > 0) begin
      check("post_we", 32'(req_we_q[0]), 32'h1);
      check("post_addr", 32'(req_addr_q[0]), 32'h0010);
      check("post_data", req_wdata_q[0], 32'h12345678);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/r4w_spi_burst_slave.md
Name: r4w_spi_burst_slave

Overview:
- Generalised SPI (mode 0) register-bus slave that replaces the fixed 16-bit-address / 32-bit-data single-access front end.
- Adds parametrised address and data widths, auto-increment burst reads and writes, a read prefetch buffer and sticky error flags.
- Sits between the top-level SPI pins and the register file (control, SF, symbol, NCO, I/Q, ID, version), all in the system clock domain.

Parameters:
- ADDR_W, 16, address field width in bits; a multiple of 8.
- DATA_W, 32, data word width in bits; a multiple of 8.
- ADDR_STRIDE, 4, address increment per burst word.
- SYNC_STAGES, 2, synchroniser flops on spi_sclk, spi_cs_n and spi_mosi; minimum 2.

Ports:
- clk  in  1  system clock; spi_sclk must be at most clk/8.
- rst_n  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock, asynchronous to clk.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- spi_miso_oe  out  1  high while selected and in the read-data phase.
- bus_req  out  1  one-cycle request strobe.
- bus_we  out  1  1 = write, 0 = read; valid with bus_req.
- bus_addr  out  ADDR_W  word address; valid with bus_req.
- bus_wdata  out  DATA_W  write data; valid with bus_req.
- bus_ack  in  1  completion strobe; for reads, bus_rdata is valid in the same cycle.
- bus_rdata  in  DATA_W  read data.
- xfer_active  out  1  synchronised chip select is asserted.
- err_underrun  out  1  sticky: read word not ready when needed.
- err_partial  out  1  sticky: frame ended mid-word.
- err_clr  in  1  clears both sticky errors.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, xfer_active=0, both error flags=0. FSM returns to IDLE.
- Synchronisers:
  - Edge detect on synchronised sclk: rise = sample, fall = shift out.
  - Falling edge of synchronised cs_n resets the bit counter and enters CMD.
  - Rising edge of synchronised cs_n returns to IDLE from any state.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA.
- CMD: 8 bits. bit7=1 selects write, 0 selects read. bit6=1 enables burst auto-increment. bits5:0 are ignored.
- ADDR: ADDR_W bits, MSB first.
  - On the last address bit of a read: issue bus_req with bus_we=0 on the next cycle.
- WDATA:
  - After every DATA_W bits: pulse bus_req with bus_we=1, the captured word and the current address.
  - If burst is set, the address then increments by ADDR_STRIDE, wrapping modulo 2^ADDR_W.
  - If burst is clear, further words keep the same address.
  - Write acks are not waited for; a new request before the previous ack is legal.
- RDATA:
  - The first data MSB is driven at the sclk falling edge that follows the last address bit.
  - A read word is loaded from the prefetch buffer at each word boundary.
  - After each load, issue a read for address+ADDR_STRIDE if burst is set, or the same address if not.
  - If the buffer is empty at a load: drive all zeros for that word and set err_underrun.
  - Only one read is outstanding at a time.
- MOSI during RDATA is ignored.
- If cs_n deasserts with a nonzero partial word in ADDR or WDATA: no bus request is issued and err_partial is set.
- Simultaneous err_clr and a new error event: the error wins.
- Reset mid-frame: the slave stays IDLE until the next cs_n falling edge. A bus_ack arriving while IDLE is discarded.

Decomposition:
- Shared package r4w_spi_pkg:
  - State enum.
  - CMD_WRITE_BIT=7, CMD_BURST_BIT=6.
  - Register address constants (CTRL 0x00, SF 0x04, STATUS 0x08, SYMBOL 0x0C, NCO_FREQ 0x10, NCO_PHASE 0x14, DATA_I 0x18, DATA_Q 0x1C, ID 0x20, VERSION 0x24).
- One sub-module, r4w_spi_sync_edge: SYNC_STAGES-deep synchroniser plus rise/fall detect, instantiated for sclk and cs_n. MOSI uses the synchroniser only.

Test Plan:
- Single write 0x80, 0x0004, 0x00000008 -> exactly one bus_req, with bus_we=1, bus_addr=0x0004, bus_wdata=0x00000008.
- Single read 0x00, 0x0020, with the model returning 0x52344C49 after a 2-cycle ack -> MISO bytes 52 34 4C 49; err_underrun stays 0.
- Burst write 0xC0, 0x0010, then words 0x00010000, 0x00000011, 0x00000022 -> three requests at 0x0010, 0x0014, 0x0018. Then 0xC0, 0xFFFC with two words -> second request at address 0x0000 (wrap).
- Burst read 0x40, 0x0018, three words, with the model returning addr*2 -> MISO words 0x30, 0x38, 0x40. Read requests at 0x18, 0x1C, 0x20, 0x24 (the last is a prefetch).
- Slow model (ack after 40 clk at sclk=clk/8) -> first word reads 0x00000000 and err_underrun=1. After an err_clr pulse, err_underrun=0.
- Abort: cs_n rises after 12 bits of a write data word -> no write request and err_partial=1. Separately, rst_n low mid-ADDR -> all outputs at reset values, and the next full transaction succeeds.
